// File: rtl/ctrl_seq.sv
// SAP-1 controller-sequencer: 6-state ring advanced by panel-clock falls, decoded to the 12-bit control word.
// Latency: ring advances at the clk edge that ends the first cycle CLK is sampled low; nHLT follows halt by 1 clk.
// Backpressure: none; run=0 parks the ring at T1 with the bus idle, and halt freezes it at T4 until CLR.
module ctrl_seq #(
    parameter int          TSTATES  = 6,
    parameter logic [11:0] CON_IDLE = 12'h3E3
) (
    input  logic                 clk,
    input  logic                 CLR,
    input  logic                 CLK,
    input  logic                 run,
    input  logic [3:0]           opcode,
    output logic [11:0]          con,
    output logic [TSTATES-1:0]   tstate,
    output logic                 nHLT
);

    localparam logic [TSTATES-1:0] T1 = 6'b000001;
    localparam logic [TSTATES-1:0] T2 = 6'b000010;
    localparam logic [TSTATES-1:0] T3 = 6'b000100;
    localparam logic [TSTATES-1:0] T4 = 6'b001000;
    localparam logic [TSTATES-1:0] T5 = 6'b010000;
    localparam logic [TSTATES-1:0] T6 = 6'b100000;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    logic clk_d;
    logic halted;
    logic fall;
    logic set_halt;

    assign fall     = clk_d & ~CLK;
    assign set_halt = run & (tstate == T4) & (opcode == OP_HLT);

    always_ff @(posedge clk) begin
        if (CLR) begin
            tstate <= T1;
            clk_d  <= 1'b0;
            halted <= 1'b0;
        end else begin
            clk_d <= CLK;
            if (set_halt)
                halted <= 1'b1;
            // Halt is taken in the T4 cycle itself so no fall can slip past it.
            if (!$onehot(tstate) || !run)
                tstate <= T1;
            else if (fall && !halted && !set_halt)
                tstate <= {tstate[TSTATES-2:0], tstate[TSTATES-1]};
        end
    end

    assign nHLT = CLR | ~halted;

    always_comb begin
        con = CON_IDLE;
        if (!CLR && run && !halted) begin
            case (tstate)
                T1: con = 12'h5E3;
                T2: con = 12'hBE3;
                T3: con = 12'h263;
                T4: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB: con = 12'h1A3;
                        OP_OUT:                 con = 12'h3F2;
                        default:                con = CON_IDLE;
                    endcase
                end
                T5: begin
                    case (opcode)
                        OP_LDA:         con = 12'h2C3;
                        OP_ADD, OP_SUB: con = 12'h2E1;
                        default:        con = CON_IDLE;
                    endcase
                end
                T6: begin
                    case (opcode)
                        OP_ADD:  con = 12'h3C7;
                        OP_SUB:  con = 12'h3CF;
                        default: con = CON_IDLE;
                    endcase
                end
                default: con = CON_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Controller-sequencer of the SAP-1: sits directly downstream of the front-panel input block.
- Consumes the panel's CLK, CLR and run signals and the instruction register's opcode nibble.
- Produces the 12-bit control word that drives every bus-facing register, plus the nHLT line that the panel uses to freeze its auto clock.
- Clocked on the fast board clock; detects panel-clock falling edges to advance a 6-state ring counter.

Parameters:
- TSTATES, 6, number of T-states per instruction (ring length; fixed at 6 for this instruction set)
- CON_IDLE, 12'h3E3, inactive control word (all active-low bits high, active-high bits low)

Ports:
- clk  input  1  board clock; all state updates on its rising edge
- CLR  input  1  synchronous active-high reset (panel clear)
- CLK  input  1  panel computer clock (level, synchronous to clk)
- run  input  1  1 = execute mode, 0 = programming mode
- opcode  input  4  IR[7:4], valid from T4 onward
- con  output  12  control word {Cp,Ep,nLm,nCE,nLi,nEi,nLa,Ea,Su,Eu,nLb,nLo}, MSB first
- tstate  output  6  one-hot ring state, bit0 = T1
- nHLT  output  1  active-low halt to the panel

Behaviour:
- Registers: clk_d (previous CLK), tstate (one-hot), halted.
- CLR = 1 at a clk edge: tstate <= 6'b000001, clk_d <= 0, halted <= 0. While CLR = 1, con = CON_IDLE and nHLT = 1. Reset mid-instruction abandons the instruction; execution restarts at T1.
- Edge detect: clk_d <= CLK every cycle (when not in CLR). fall = clk_d & ~CLK.
  - Clearing clk_d to 0 guarantees no spurious fall immediately after CLR.
  - Rising CLK edges are ignored; registers elsewhere load on the CLK rise while con is stable.
- Ring: on fall with run = 1 and halted = 0, tstate rotates left: T1→T2→…→T6→T1.
  - Exactly one advance per CLK falling edge, visible on tstate one clk after the clk cycle where CLK is first sampled low.
- run = 0:
  - tstate is forced to T1 on each clk; falls are ignored.
  - con = CON_IDLE, so the panel owns the buses.
  - halted is held.
- halted: set in any clk cycle where run = 1, tstate = T4 and opcode = 4'hF. nHLT = ~halted, registered (1 clk latency).
  - While halted, tstate is frozen at T4 even if falls arrive; con = CON_IDLE.
  - Only CLR clears halted.
- con decode (combinational from tstate, opcode, run, CLR, halted):
  - T1 5E3 (Ep, nLm)
  - T2 BE3 (Cp)
  - T3 263 (nCE, nLi)
  - LDA 0000: T4 1A3, T5 2C3, T6 3E3
  - ADD 0001: T4 1A3, T5 2E1, T6 3C7
  - SUB 0010: T4 1A3, T5 2E1, T6 3CF
  - OUT 1110: T4 3F2, T5 3E3, T6 3E3
  - HLT 1111: T4–T6 3E3
  - Other opcodes: T4–T6 3E3 (NOP)
- opcode is sampled combinationally, not latched. It must stay stable from T4 through T6; this is guaranteed because IR loads only in T3.
- tstate is always exactly one-hot. Any illegal encoding recovers to T1 on the next clk.

Test Plan:
- Reset/idle: assert CLR 2 cycles, run = 1, CLK = 0 → tstate = 000001, con = 3E3, nHLT = 1. Release CLR with CLK = 1 → no advance on release.
- Fetch: run = 1, 3 CLK high/low periods → tstate 000001→000010→000100→001000, one clk after each fall. con shows 5E3, BE3, 263 in turn. Rising edges cause no change.
- ADD: opcode = 0001, step T4..T6 → con 1A3, 2E1, 3C7. Next fall returns to T1 with con = 5E3. SUB repeat with opcode = 0010 → T6 con = 3CF.
- OUT and undefined: opcode = 1110 → T4 con = 3F2. opcode = 0101 → T4–T6 con = 3E3 and the ring still wraps to T1.
- Halt: opcode = 1111, reach T4 → nHLT = 0 one clk later, con = 3E3. Apply 5 more CLK falls → tstate stays 001000. Pulse CLR → nHLT = 1, tstate = T1.
- Programming mode: at T5 drop run → next clk tstate = T1, con = 3E3. Toggle CLK 4 times → no advance. Raise run → fetch resumes from T1 on the next fall.
